sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/irrigation_pkg.sv | 18 +
 rtl/sensor_conditioner_if.sv | 11 +
 rtl/persist_filter.sv | 44 ++++
 rtl/sensor_conditioner.sv | 127 ++++++++++++
 tb/tb_sensor_conditioner.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and default constants for the irrigation sensor path.
package irrigation_pkg;

    // Moisture averaging FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EVAL  = 2'd2
    } state_t;

    localparam int unsigned DEF_SAMPLE_W     = 10;
    localparam int unsigned DEF_AVG_LOG2     = 2;
    localparam int unsigned DEF_DRY_ON_TH    = 300;
    localparam int unsigned DEF_WET_OFF_TH   = 400;
    localparam int unsigned DEF_RAIN_PERSIST = 1000;
    localparam int unsigned DEF_TIMEOUT      = 65535;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Valid/ready moisture sample bus from the ADC front end.
interface sensor_conditioner_if #(
    parameter int unsigned SAMPLE_W = 10
) ();
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_ready;

    modport master (output sample_valid, output sample_data, input sample_ready);
    modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/persist_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only
// follows the synchronised input after CYCLES consecutive disagreeing cycles.
module persist_filter #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous contact into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreement; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync2 != dout) begin
            if (cnt == CNT_W'(CYCLES - 1)) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

// File: rtl/sensor_conditioner.sv
// Moisture averaging with dry/wet hysteresis and filtered rain flag.
// Optional sample-timeout fail-safe is enabled by defining SENSOR_TIMEOUT_EN.
module sensor_conditioner
    import irrigation_pkg::*;
#(
    parameter int unsigned SAMPLE_W     = DEF_SAMPLE_W,
    parameter int unsigned AVG_LOG2     = DEF_AVG_LOG2,
    parameter int unsigned DRY_ON_TH    = DEF_DRY_ON_TH,
    parameter int unsigned WET_OFF_TH   = DEF_WET_OFF_TH,
    parameter int unsigned RAIN_PERSIST = DEF_RAIN_PERSIST,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    sensor_conditioner_if.slave  smp,
    input  logic                 rain_raw,
    output logic                 moisture_dry,
    output logic                 rain,
    output logic [SAMPLE_W-1:0]  moisture_avg,
    output logic                 avg_valid,
    output logic                 sensor_fault
);
    localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] cnt;
    logic                ready_q;
    logic                dry_q;
    logic                xfer;
    logic [SAMPLE_W-1:0] avg_next;

    assign smp.sample_ready = ready_q;
    assign xfer             = smp.sample_valid & ready_q;
    // Truncating divide by the window size.
    assign avg_next         = SAMPLE_W'(acc >> AVG_LOG2);

    // Window FSM: accumulate 2^AVG_LOG2 samples, then evaluate for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            acc          <= '0;
            cnt          <= '0;
            ready_q      <= 1'b1;
            moisture_avg <= '0;
            avg_valid    <= 1'b0;
            dry_q        <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (xfer) begin
                        acc   <= ACC_W'(smp.sample_data);
                        cnt   <= cnt + AVG_LOG2'(1);
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        acc <= acc + ACC_W'(smp.sample_data);
                        cnt <= cnt + AVG_LOG2'(1);
                        if (cnt == '1) begin
                            state   <= S_EVAL;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_EVAL: begin
                    moisture_avg <= avg_next;
                    avg_valid    <= 1'b1;
                    acc          <= '0;
                    ready_q      <= 1'b1;
                    state        <= S_IDLE;
                    // Between the thresholds the previous flag is held.
                    if (avg_next <= SAMPLE_W'(DRY_ON_TH)) begin
                        dry_q <= 1'b1;
                    end else if (avg_next >= SAMPLE_W'(WET_OFF_TH)) begin
                        dry_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef SENSOR_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            fault_q;

    // Count idle cycles since the last transfer; saturate at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            fault_q <= 1'b0;
        end else if (xfer) begin
            to_cnt  <= '0;
            fault_q <= 1'b0;
        end else if (to_cnt != TO_W'(TIMEOUT)) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign sensor_fault = fault_q;
    // A stale sensor must never request watering.
    assign moisture_dry = dry_q & ~fault_q;
`else
    assign sensor_fault = 1'b0;
    assign moisture_dry = dry_q;
`endif

    persist_filter #(
        .CYCLES (RAIN_PERSIST)
    ) u_rain_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (rain_raw),
        .dout (rain)
    );
endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: expected averages/dry flags are
// queued at stimulus time and checked by a monitor on each avg_valid pulse.
module tb_sensor_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rain_raw = 1'b0;
    logic       moisture_dry;
    logic       rain;
    logic [9:0] moisture_avg;
    logic       avg_valid;
    logic       sensor_fault;

    typedef struct {
        logic [9:0] avg;
        logic       dry;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pulses = 0;

    sensor_conditioner_if #(.SAMPLE_W(10)) smp ();

    sensor_conditioner #(
        .SAMPLE_W     (10),
        .AVG_LOG2     (2),
        .DRY_ON_TH    (300),
        .WET_OFF_TH   (400),
        .RAIN_PERSIST (1000),
        .TIMEOUT      (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .smp          (smp),
        .rain_raw     (rain_raw),
        .moisture_dry (moisture_dry),
        .rain         (rain),
        .moisture_avg (moisture_avg),
        .avg_valid    (avg_valid),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: compare each published average against the queued expectation.
    always @(negedge clk) begin
        if (!rst && avg_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_avg: got %0d, required no pulse", moisture_avg);
            end else begin
                mon_e = exp_q.pop_front();
                check("avg", 32'(moisture_avg), 32'(mon_e.avg));
                check("dry", 32'(moisture_dry), 32'(mon_e.dry));
            end
        end
    end

    task automatic send(input logic [9:0] d);
        @(negedge clk);
        smp.sample_valid = 1'b1;
        smp.sample_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (smp.sample_ready) begin
                @(posedge clk);
                #1;
                smp.sample_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        smp.sample_valid = 1'b0;
        $display("FAIL send_timeout: got ready=0 for 20 cycles, required ready=1");
    endtask

    task automatic expect_avg(input logic [9:0] a, input logic dry);
        exp_t e;
        e.avg = a;
        e.dry = dry;
        exp_q.push_back(e);
        pushes++;
    endtask

    task automatic window(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2,
                          input logic [9:0] s3, input logic [9:0] a, input logic dry);
        expect_avg(a, dry);
        send(s0);
        send(s1);
        send(s2);
        send(s3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        smp.sample_valid = 1'b0;
        smp.sample_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_avg", 32'(moisture_avg), 0);
        check("rst_valid", 32'(avg_valid), 0);
        check("rst_dry", 32'(moisture_dry), 0);
        check("rst_rain", 32'(rain), 0);
        check("rst_fault", 32'(sensor_fault), 0);
        check("rst_ready", 32'(smp.sample_ready), 1);
        rst = 1'b0;

        window(200, 200, 200, 200, 200, 1'b1);
        window(340, 360, 350, 350, 350, 1'b1);   // between thresholds: hold
        window(450, 450, 450, 450, 450, 1'b0);
        window(300, 300, 300, 300, 300, 1'b1);   // exactly DRY_ON_TH
        window(399, 399, 399, 400, 399, 1'b1);   // truncates to 399: hold
        window(400, 400, 400, 400, 400, 1'b0);   // exactly WET_OFF_TH
        window(1023, 1023, 1023, 1022, 1022, 1'b0);
        window(200, 200, 200, 200, 200, 1'b1);
        repeat (3) @(posedge clk);

        // Partial window then reset: the two samples of 100 must be dropped.
        send(100);
        send(100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_avg", 32'(moisture_avg), 0);
        check("midrst_dry", 32'(moisture_dry), 0);
        check("midrst_ready", 32'(smp.sample_ready), 1);
        rst = 1'b0;
        window(500, 500, 500, 500, 500, 1'b0);
        repeat (3) @(posedge clk);

        // Rain: a 999-cycle pulse is rejected.
        @(negedge clk);
        rain_raw = 1'b1;
        repeat (999) @(posedge clk);
        @(negedge clk);
        rain_raw = 1'b0;
        repeat (1100) @(posedge clk);
        #1;
        check("rain_short_pulse", 32'(rain), 0);

        // Held rain rises 1000 cycles plus 2 synchroniser cycles later,
        // while a moisture window runs in parallel.
        @(negedge clk);
        rain_raw = 1'b1;
        fork
            begin
                repeat (1001) @(posedge clk);
                #1;
                check("rain_early", 32'(rain), 0);
                @(posedge clk);
                #1;
                check("rain_rise", 32'(rain), 1);
            end
            begin
                repeat (50) @(posedge clk);
                window(250, 250, 250, 250, 250, 1'b1);
            end
        join
        @(negedge clk);
        rain_raw = 1'b0;
        repeat (1005) @(posedge clk);
        #1;
        check("rain_fall", 32'(rain), 0);

`ifdef SENSOR_TIMEOUT_EN
        window(200, 200, 200, 200, 200, 1'b1);
        repeat (99) @(posedge clk);
        #1;
        check("to_fault_early", 32'(sensor_fault), 0);
        check("to_dry_early", 32'(moisture_dry), 1);
        @(posedge clk);
        #1;
        check("to_fault_set", 32'(sensor_fault), 1);
        check("to_dry_forced", 32'(moisture_dry), 0);
        expect_avg(200, 1'b1);
        send(200);
        check("to_fault_clear", 32'(sensor_fault), 0);
        check("to_dry_restore", 32'(moisture_dry), 1);
        send(200);
        send(200);
        send(200);
`else
        repeat (200) @(posedge clk);
        #1;
        check("fault_tied_low", 32'(sensor_fault), 0);
`endif

        repeat (10) @(posedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 0);
        check("pulse_count", 32'(pulses), 32'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
